// File: rtl/packet_framer_if.sv
// Byte-stream and modulator handshake bundle for packet_framer.
// slave = framer side, master = byte source / modulator side.
interface packet_framer_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] frame_bits;
  logic         mod_start;
  logic         mod_done;
  logic         busy;
  logic         frame_sent;

  modport slave (
    input  in_data, in_valid, mod_done,
    output in_ready, frame_bits, mod_start, busy, frame_sent
  );

  modport master (
    output in_data, in_valid, mod_done,
    input  in_ready, frame_bits, mod_start, busy, frame_sent
  );
endinterface

// File: rtl/packet_framer.sv
// Collects a 10-byte payload, runs a bit-serial CRC-16/CCITT-FALSE and hands a 128-bit frame
// to the modulator via start/done. Optional PN9 whitening of bits [95:0] under FRAMER_WHITEN_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// COLLECT    | idle / waiting for the next payload byte (in_ready=1)
// CRC_SHIFT  | 8 cycles, one payload bit per cycle into the CRC
// LAUNCH     | write CRC, preamble and sync word into the frame
// WHITEN     | (FRAMER_WHITEN_EN only) 16 cycles whitening the CRC bits
// START_WAIT | mod_start high until mod_done is seen
// DONE_WAIT  | wait for mod_done release, then pulse frame_sent
module packet_framer #(
  parameter logic [15:0] PREAMBLE  = 16'hAAAA,
  parameter logic [15:0] SYNC_WORD = 16'h2DD4,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF,
  parameter logic [15:0] CRC_POLY  = 16'h1021
) (
  input logic           clk,
  input logic           reset,
  packet_framer_if.slave bus
);

  typedef enum logic [2:0] {
    COLLECT    = 3'd0,
    CRC_SHIFT  = 3'd1,
    LAUNCH     = 3'd2,
`ifdef FRAMER_WHITEN_EN
    WHITEN     = 3'd5,
`endif
    START_WAIT = 3'd3,
    DONE_WAIT  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [15:0]    crc_q, crc_d;
  logic [7:0]     shift_q, shift_d;
  logic [127:0]   frame_q, frame_d;
  logic           mod_start_q, mod_start_d;
  logic           frame_sent_q, frame_sent_d;
  logic [6:0]     byte_base;
`ifdef FRAMER_WHITEN_EN
  logic [8:0]     lfsr_q, lfsr_d;
  logic [3:0]     wh_cnt_q, wh_cnt_d;
  logic [6:0]     bit_idx;
  logic [6:0]     wh_idx;
`endif

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
  endfunction

  assign bus.in_ready   = (state_q == COLLECT);
  assign bus.busy       = (state_q != COLLECT);
  assign bus.mod_start  = mod_start_q;
  assign bus.frame_sent = frame_sent_q;
  assign bus.frame_bits = frame_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    crc_d        = crc_q;
    shift_d      = shift_q;
    frame_d      = frame_q;
    mod_start_d  = 1'b0;
    frame_sent_d = 1'b0;
    byte_base    = 7'd95 - {byte_cnt_q, 3'b000};
`ifdef FRAMER_WHITEN_EN
    lfsr_d       = lfsr_q;
    wh_cnt_d     = wh_cnt_q;
    // Bit currently shifting belongs to the byte already counted in byte_cnt.
    bit_idx      = 7'd95 - {byte_cnt_q - 4'd1, 3'b000} - {4'b0000, bit_cnt_q};
    wh_idx       = {3'b000, wh_cnt_q};
`endif

    case (state_q)
      COLLECT: begin
        if (bus.in_valid) begin
          shift_d               = bus.in_data;
          frame_d[byte_base -: 8] = bus.in_data;
          byte_cnt_d            = byte_cnt_q + 4'd1;
          bit_cnt_d             = 3'd0;
          state_d               = CRC_SHIFT;
        end
      end

      CRC_SHIFT: begin
        crc_d     = crc_step(crc_q, shift_q[7]);
        shift_d   = {shift_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef FRAMER_WHITEN_EN
        frame_d[bit_idx] = shift_q[7] ^ lfsr_q[0];
        lfsr_d           = {lfsr_q[0] ^ lfsr_q[5], lfsr_q[8:1]};
`endif
        if (bit_cnt_q == 3'd7) begin
          state_d = (byte_cnt_q == 4'd10) ? LAUNCH : COLLECT;
        end
      end

      LAUNCH: begin
        frame_d[15:0]    = crc_q;
        frame_d[127:112] = PREAMBLE;
        frame_d[111:96]  = SYNC_WORD;
`ifdef FRAMER_WHITEN_EN
        wh_cnt_d = 4'd15;
        state_d  = WHITEN;
`else
        mod_start_d = 1'b1;
        state_d     = START_WAIT;
`endif
      end

`ifdef FRAMER_WHITEN_EN
      WHITEN: begin
        // Down-counter walks the CRC field MSB first; terminal count launches.
        frame_d[wh_idx] = frame_q[wh_idx] ^ lfsr_q[0];
        lfsr_d          = {lfsr_q[0] ^ lfsr_q[5], lfsr_q[8:1]};
        if (wh_cnt_q == 4'd0) begin
          mod_start_d = 1'b1;
          state_d     = START_WAIT;
        end else begin
          wh_cnt_d = wh_cnt_q - 4'd1;
        end
      end
`endif

      START_WAIT: begin
        if (bus.mod_done) begin
          state_d = DONE_WAIT;
        end else begin
          mod_start_d = 1'b1;
        end
      end

      DONE_WAIT: begin
        if (!bus.mod_done) begin
          frame_sent_d = 1'b1;
          byte_cnt_d   = 4'd0;
          crc_d        = CRC_INIT;
`ifdef FRAMER_WHITEN_EN
          lfsr_d       = 9'h1FF;
`endif
          state_d      = COLLECT;
        end
      end

      default: begin
        byte_cnt_d = 4'd0;
        bit_cnt_d  = 3'd0;
        crc_d      = CRC_INIT;
        state_d    = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= COLLECT;
      byte_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      crc_q        <= CRC_INIT;
      shift_q      <= 8'h00;
      frame_q      <= '0;
      mod_start_q  <= 1'b0;
      frame_sent_q <= 1'b0;
`ifdef FRAMER_WHITEN_EN
      lfsr_q       <= 9'h1FF;
      wh_cnt_q     <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      crc_q        <= crc_d;
      shift_q      <= shift_d;
      frame_q      <= frame_d;
      mod_start_q  <= mod_start_d;
      frame_sent_q <= frame_sent_d;
`ifdef FRAMER_WHITEN_EN
      lfsr_q       <= lfsr_d;
      wh_cnt_q     <= wh_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Directed self-checking bench for packet_framer (default build, whitening disabled).
module tb_packet_framer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  packet_framer_if bus();

  packet_framer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [79:0] payload;
  int min_gap, max_gap, early_start;
  int n;
  int cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [95:0] d, input int nbits);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < nbits; i++) begin
      fb = c[15] ^ d[95 - i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [127:0] exp_frame(input logic [79:0] p);
    return {16'hAAAA, 16'h2DD4, p, crc_model({p, 16'h0000}, 80)};
  endfunction

  function automatic logic [7:0] pbyte(input int i);
    return 8'(payload >> (8 * (9 - i)));
  endfunction

  // Feeds nbytes of payload; rnd toggles in_valid and pulses mod_done randomly.
  task automatic send_frame(input int nbytes, input bit rnd);
    int idx, cyc, last, g;
    idx = 0; cyc = 0; last = -1;
    min_gap = 1000; max_gap = 0; early_start = 0;
    bus.in_data  = pbyte(0);
    bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (idx < nbytes && cyc < 2000) begin
      if (bus.mod_start) early_start++;
      if (bus.in_ready && bus.in_valid) begin
        if (last >= 0) begin
          g = cyc - last;
          if (g < min_gap) min_gap = g;
          if (g > max_gap) max_gap = g;
        end
        last = cyc;
        idx++;
      end
      tick();
      cyc++;
      if (idx < nbytes) bus.in_data = pbyte(idx);
      bus.in_valid = (idx >= nbytes) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (rnd) bus.mod_done = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    chki("bytes_accepted", idx, nbytes);
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (!bus.mod_start && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.mod_done = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_frame_bits", bus.frame_bits, 128'h0);
    chk("rst_mod_start", bus.mod_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_sent", bus.frame_sent, 0);
    reset = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);

    // Frame 1: continuous stream 01..0A
    payload = 80'h0102030405060708090A;
    send_frame(10, 1'b0);
    chki("gap_min", min_gap, 9);
    chki("gap_max", max_gap, 9);
    chki("f1_early_start", early_start, 0);
    wait_start(n);
    chki("f1_start_latency", n, 9);
    chk("f1_hdr", bus.frame_bits[127:96], 32'hAAAA2DD4);
    chk("f1_payload", bus.frame_bits[95:16], 80'h0102030405060708090A);
    chk("f1_crc", bus.frame_bits[15:0], crc_model({payload, 16'h0000}, 80));
    chk("f1_residue", crc_model(bus.frame_bits[95:0], 96), 16'h0000);
    chk("f1_busy", bus.busy, 1);

    // Hold mod_done low 50 cycles while offering a byte that must be ignored
    bus.in_data = 8'hEE; bus.in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.mod_start && !bus.in_ready) cnt++;
    end
    chki("f1_start_held", cnt, 50);
    bus.in_valid = 1'b0;
    bus.mod_done = 1'b1;
    tick();
    chk("f1_start_fall", bus.mod_start, 0);
    chk("f1_busy_done_wait", bus.busy, 1);
    chk("f1_no_sent_early", bus.frame_sent, 0);
    tick(); tick();
    chk("f1_no_sent_held", bus.frame_sent, 0);
    bus.mod_done = 1'b0;
    tick();
    chk("f1_frame_sent", bus.frame_sent, 1);
    chk("f1_ready_at_sent", bus.in_ready, 1);
    tick();
    chk("f1_sent_pulse", bus.frame_sent, 0);
    chk("f1_ready_after", bus.in_ready, 1);
    chk("f1_frame_kept", bus.frame_bits, exp_frame(80'h0102030405060708090A));

    // Frame 2: back-pressure and spurious done, done already high at START_WAIT
    payload = 80'hDEADBEEF00FF55AA1234;
    send_frame(10, 1'b1);
    chki("f2_early_start", early_start, 0);
    bus.mod_done = 1'b1;
    wait_start(n);
    chki("f2_start_latency", n, 9);
    chk("f2_frame", bus.frame_bits, exp_frame(80'hDEADBEEF00FF55AA1234));
    chk("f2_residue", crc_model(bus.frame_bits[95:0], 96), 16'h0000);
    tick();
    chk("f2_start_one_cycle", bus.mod_start, 0);
    bus.mod_done = 1'b0;
    tick();
    chk("f2_frame_sent", bus.frame_sent, 1);

    // Reset during START_WAIT
    payload = 80'h11223344556677889900;
    send_frame(10, 1'b0);
    wait_start(n);
    chki("f3_start_latency", n, 9);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rstA_mod_start", bus.mod_start, 0);
    chk("rstA_busy", bus.busy, 0);
    chk("rstA_frame_sent", bus.frame_sent, 0);
    chk("rstA_frame_bits", bus.frame_bits, 128'h0);
    tick();
    reset = 1'b1;
    tick();

    // Reset during CRC_SHIFT of byte 5
    payload = 80'hA5A5A5A5A5A5A5A5A5A5;
    send_frame(5, 1'b0);
    tick(); tick();
    chk("rstB_busy_before", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("rstB_busy", bus.busy, 0);
    chk("rstB_mod_start", bus.mod_start, 0);
    chk("rstB_frame_sent", bus.frame_sent, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rstB_in_ready", bus.in_ready, 1);

    // Full frame after aborted one must use a fresh CRC
    payload = 80'h3132333435363738397E;
    send_frame(10, 1'b0);
    wait_start(n);
    chki("f5_start_latency", n, 9);
    chk("f5_frame", bus.frame_bits, exp_frame(80'h3132333435363738397E));
    chk("f5_residue", crc_model(bus.frame_bits[95:0], 96), 16'h0000);
    bus.mod_done = 1'b1;
    tick();
    chk("f5_start_fall", bus.mod_start, 0);
    bus.mod_done = 1'b0;
    tick();
    chk("f5_frame_sent", bus.frame_sent, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_framer.md
Name: packet_framer

Overview:
- Upstream feeder for the bit-serial modulator.
- Collects a fixed 10-byte payload over a valid/ready byte interface and computes CRC-16/CCITT-FALSE bit-serially.
- Assembles a 128-bit frame (preamble, sync word, payload, CRC), then runs the start/done handshake with the modulator.
- Returns to collecting only after the modulator has released done.

Parameters:
- PREAMBLE, 16'hAAAA, frame bits [127:112].
- SYNC_WORD, 16'h2DD4, frame bits [111:96].
- CRC_INIT, 16'hFFFF, CRC register value at the start of each frame.
- CRC_POLY, 16'h1021, CRC generator polynomial (MSB-first, no reflection, no final XOR).

Ports:
- clk  in  1  single clock domain, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  framer can accept a byte this cycle.
- frame_bits  out  128  assembled frame; drives the modulator in_bitstream.
- mod_start  out  1  drives the modulator start.
- mod_done  in  1  from the modulator done.
- busy  out  1  high in every state except COLLECT.
- frame_sent  out  1  one-cycle pulse when a frame's handshake completes.

Behaviour:
- Reset (reset=0, async):
  - state=COLLECT, byte_cnt=0, bit_cnt=0, crc=CRC_INIT.
  - frame_bits=0, mod_start=0, busy=0, frame_sent=0.
  - in_ready=1 once reset is released.
- Reset mid-operation aborts the frame: partial payload is discarded, mod_start drops asynchronously to 0.
- Byte count is fixed at 10; byte_cnt is 4 bits (0..10).
- States:
  - COLLECT:
    - in_ready=1, busy=0.
    - On in_valid&&in_ready: latch the byte into a shift register, write it to frame_bits[95-8*byte_cnt -: 8], byte_cnt++, go to CRC_SHIFT with bit_cnt=0.
  - CRC_SHIFT:
    - in_ready=0; exactly 8 cycles, one payload bit per cycle, MSB first.
    - Per bit: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0).
    - At bit_cnt==7: go to LAUNCH if byte_cnt==10, else go to COLLECT.
    - Byte throughput is therefore one byte per 9 cycles.
  - LAUNCH:
    - Write frame_bits[15:0]=crc, [127:112]=PREAMBLE, [111:96]=SYNC_WORD.
    - Go to START_WAIT next cycle (WHITEN instead if the macro is enabled).
  - START_WAIT:
    - mod_start=1; frame_bits held stable.
    - On mod_done==1: mod_start=0 (registered, next cycle), go to DONE_WAIT.
  - DONE_WAIT:
    - mod_start=0; wait for mod_done==0.
    - Then pulse frame_sent for 1 cycle, clear byte_cnt, set crc=CRC_INIT, go to COLLECT.
- Latency: first cycle of mod_start=1 is 2 cycles after the 10th CRC_SHIFT cycle (without the macro).
- frame_bits keeps the previous frame until overwritten byte-by-byte by the next frame.
- Boundary conditions:
  - in_valid while in_ready=0: ignored; the source must hold data.
  - mod_done high in COLLECT, CRC_SHIFT or LAUNCH: ignored.
  - mod_done already high on entry to START_WAIT: transition taken on the first START_WAIT cycle.
  - in_valid during START_WAIT/DONE_WAIT: not accepted.
  - Illegal state encoding: return to COLLECT.
- Outputs mod_start, frame_sent, in_ready and busy are registered or state-decoded with no input-to-output combinational path.

Optional Feature:
- Macro FRAMER_WHITEN_EN.
- When defined:
  - frame_bits[95:0] (payload plus CRC) is XORed with a PN9 stream; the CRC is computed over un-whitened data.
  - LFSR s[8:0] is seeded 9'h1FF at the start of each frame; per bit, output w=s[0], next s={s[0]^s[5], s[8:1]}.
  - Payload bits are whitened in CRC_SHIFT as they are stored.
  - An extra WHITEN state (16 cycles) sits between LAUNCH and START_WAIT and whitens bits [15:0] MSB first. This adds 16 cycles of latency.
- When undefined: no LFSR, no WHITEN state, frame_bits carries raw payload and CRC.

Test Plan:
- Reset, then stream bytes 8'h01..8'h0A with in_valid held high -> in_ready high exactly 1 cycle in 9; frame_bits[127:96]=32'hAAAA2DD4; frame_bits[95:16]=80'h0102030405060708090A; mod_start rises 2 cycles after the final CRC cycle.
- CRC check -> bench model of CRC-16/CCITT-FALSE over the payload equals frame_bits[15:0]; CRC over frame_bits[95:0] MSB-first from init 16'hFFFF gives residue 16'h0000.
- Handshake: mod_done asserted 50 cycles after mod_start, held 3 cycles then dropped -> mod_start falls the cycle after mod_done rises; frame_sent is a single pulse 1 cycle after mod_done falls; in_ready=1 on the following cycle.
- Back-pressure and spurious done: in_valid toggled randomly, mod_done pulsed during COLLECT -> all 10 bytes land in order, no extra acceptance, no mod_start before byte 10.
- Reset mid-operation (deassert reset during START_WAIT and during CRC_SHIFT of byte 5) -> mod_start=0, busy=0, frame_sent=0 immediately; the next 10-byte frame yields a correct CRC.
- With FRAMER_WHITEN_EN and an all-zero payload -> frame_bits[95:88]=8'hFF (first 8 PN9 bits); mod_start is delayed by 16 extra cycles.
